// File: rtl/accum_pkg.sv
// Shared types and default sizing for the product accumulator block.
package accum_pkg;

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_t;

  localparam int DEFAULT_DATA_W = 16;
  localparam int DEFAULT_ACC_W  = 32;
  localparam int DEFAULT_COUNT  = 8;

endpackage

// File: rtl/product_accumulator_if.sv
// Sample-in / result-out bus of the product accumulator, plus its synchronous clear.
interface product_accumulator_if
  import accum_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int ACC_W  = DEFAULT_ACC_W
);
  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;
  logic              clear;
  logic [ACC_W-1:0]  out_data;
  logic              out_overflow;
  logic              out_valid;
  logic              out_ready;

  modport master (
    output in_data, in_valid, clear, out_ready,
    input  in_ready, out_data, out_overflow, out_valid
  );

  modport slave (
    input  in_data, in_valid, clear, out_ready,
    output in_ready, out_data, out_overflow, out_valid
  );
endinterface

// File: rtl/product_accumulator_sat_add.sv
// Combinational accumulator adder; clamps to all-ones on carry when
// PRODUCT_ACCUMULATOR_SATURATE_EN is defined, otherwise wraps.
module sat_add #(
  parameter int ACC_W = 32
) (
  input  logic [ACC_W-1:0] acc,
  input  logic [ACC_W-1:0] sample,
  output logic [ACC_W-1:0] sum,
  output logic             carry
);
  logic [ACC_W-1:0] raw_sum;

  assign {carry, raw_sum} = {1'b0, acc} + {1'b0, sample};

`ifdef PRODUCT_ACCUMULATOR_SATURATE_EN
  // Once clamped, any further nonzero sample carries again, so the clamp persists.
  assign sum = carry ? {ACC_W{1'b1}} : raw_sum;
`else
  assign sum = raw_sum;
`endif
endmodule

// File: rtl/product_accumulator.sv
// Sums blocks of COUNT unsigned products and holds each total on a valid/ready
// output. Saturating build selected by PRODUCT_ACCUMULATOR_SATURATE_EN.
module product_accumulator
  import accum_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int ACC_W  = DEFAULT_ACC_W,
  parameter int COUNT  = DEFAULT_COUNT
) (
  input  logic                 clk,
  input  logic                 rst,
  product_accumulator_if.slave bus
);
  localparam int CNT_W = $clog2(COUNT + 1);

  state_t           state, state_nxt;
  logic [ACC_W-1:0] acc, acc_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             ovf, ovf_nxt;
  logic [ACC_W-1:0] out_data_nxt;
  logic             out_overflow_nxt;
  logic             out_valid_nxt;
  logic [ACC_W-1:0] add_sum;
  logic             add_carry;
  logic             accept;

  assign bus.in_ready = (state == ACCUM) && !rst;
  assign accept       = bus.in_valid && bus.in_ready;

  sat_add #(.ACC_W(ACC_W)) u_sat_add (
    .acc    (acc),
    .sample (ACC_W'(bus.in_data)),
    .sum    (add_sum),
    .carry  (add_carry)
  );

  // NOTE: every output of this block gets a default first so no path leaves a latch.
  always_comb begin
    state_nxt        = state;
    acc_nxt          = acc;
    cnt_nxt          = cnt;
    ovf_nxt          = ovf;
    out_data_nxt     = bus.out_data;
    out_overflow_nxt = bus.out_overflow;
    out_valid_nxt    = bus.out_valid;

    if (bus.clear) begin
      state_nxt     = ACCUM;
      acc_nxt       = '0;
      cnt_nxt       = '0;
      ovf_nxt       = 1'b0;
      out_valid_nxt = 1'b0;
    end else begin
      unique case (state)
        ACCUM: begin
          if (accept) begin
            acc_nxt = add_sum;
            ovf_nxt = ovf | add_carry;
            cnt_nxt = cnt + CNT_W'(1);
            if (cnt == CNT_W'(COUNT - 1)) begin
              state_nxt        = HOLD;
              out_data_nxt     = add_sum;
              out_overflow_nxt = ovf | add_carry;
              out_valid_nxt    = 1'b1;
            end
          end
        end
        HOLD: begin
          if (bus.out_valid && bus.out_ready) begin
            state_nxt     = ACCUM;
            acc_nxt       = '0;
            cnt_nxt       = '0;
            ovf_nxt       = 1'b0;
            out_valid_nxt = 1'b0;
          end
        end
        default: state_nxt = ACCUM;
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= ACCUM;
      acc              <= '0;
      cnt              <= '0;
      ovf              <= 1'b0;
      bus.out_data     <= '0;
      bus.out_overflow <= 1'b0;
      bus.out_valid    <= 1'b0;
    end else begin
      state            <= state_nxt;
      acc              <= acc_nxt;
      cnt              <= cnt_nxt;
      ovf              <= ovf_nxt;
      bus.out_data     <= out_data_nxt;
      bus.out_overflow <= out_overflow_nxt;
      bus.out_valid    <= out_valid_nxt;
    end
  end
endmodule

// File: tb/tb_product_accumulator.sv
// Directed bench: default block of 8, a 17-bit/COUNT=4 overflow instance and a COUNT=1 instance.
module tb_product_accumulator;
  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  product_accumulator_if #(.DATA_W(16), .ACC_W(32)) bus0 ();
  product_accumulator_if #(.DATA_W(16), .ACC_W(17)) bus1 ();
  product_accumulator_if #(.DATA_W(16), .ACC_W(32)) bus2 ();

  product_accumulator #(.DATA_W(16), .ACC_W(32), .COUNT(8)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
  product_accumulator #(.DATA_W(16), .ACC_W(17), .COUNT(4)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
  product_accumulator #(.DATA_W(16), .ACC_W(32), .COUNT(1)) dut2 (.clk(clk), .rst(rst), .bus(bus2));

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [16:0] exp_ovf_sum;

  initial begin
    rst = 1'b1;
    bus0.in_data = '0; bus0.in_valid = 1'b0; bus0.clear = 1'b0; bus0.out_ready = 1'b0;
    bus1.in_data = '0; bus1.in_valid = 1'b0; bus1.clear = 1'b0; bus1.out_ready = 1'b0;
    bus2.in_data = '0; bus2.in_valid = 1'b0; bus2.clear = 1'b0; bus2.out_ready = 1'b0;
    step();
    step();
    check("rst_out_valid", bus0.out_valid, 0);
    check("rst_out_data", bus0.out_data, 0);
    check("rst_out_overflow", bus0.out_overflow, 0);
    check("rst_in_ready_low", bus0.in_ready, 0);
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", bus0.in_ready, 1);

    // Block of 1..8 -> 36, visible the cycle after the 8th accept.
    for (int i = 1; i <= 8; i++) begin
      bus0.in_valid = 1'b1;
      bus0.in_data  = 16'(i);
      step();
      if (i == 7) check("t1_no_early_valid", bus0.out_valid, 0);
    end
    check("t1_out_valid", bus0.out_valid, 1);
    check("t1_out_data", bus0.out_data, 36);
    check("t1_out_overflow", bus0.out_overflow, 0);
    check("t1_in_ready_hold", bus0.in_ready, 0);

    // Stall 5 cycles with in_valid high; nothing accepted, result stable.
    bus0.in_data = 16'd99;
    for (int i = 0; i < 5; i++) begin
      step();
      check("t2_stall_in_ready", bus0.in_ready, 0);
      check("t2_stall_data", bus0.out_data, 36);
    end
    bus0.out_ready = 1'b1;
    step();
    bus0.out_ready = 1'b0;
    check("t2_hs_out_valid", bus0.out_valid, 0);
    check("t2_hs_in_ready", bus0.in_ready, 1);
    check("t2_hold_data_after_hs", bus0.out_data, 36);
    for (int i = 0; i < 8; i++) begin
      bus0.in_data = 16'd1;
      step();
    end
    bus0.in_valid = 1'b0;
    check("t2_new_block_from_zero", bus0.out_data, 8);
    bus0.out_ready = 1'b1;
    step();
    bus0.out_ready = 1'b0;

    // Three 10s, then clear with a 4th valid sample; next 8 twos -> 16.
    bus0.in_valid = 1'b1;
    bus0.in_data  = 16'd10;
    step(); step(); step();
    bus0.clear = 1'b1;
    step();
    bus0.clear = 1'b0;
    check("t4_clear_no_valid", bus0.out_valid, 0);
    check("t4_clear_in_ready", bus0.in_ready, 1);
    bus0.in_data = 16'd2;
    for (int i = 0; i < 8; i++) step();
    bus0.in_valid = 1'b0;
    check("t4_out_valid", bus0.out_valid, 1);
    check("t4_out_data", bus0.out_data, 16);
    bus0.out_ready = 1'b1;
    step();
    bus0.out_ready = 1'b0;

    // Reset during HOLD with 36 pending.
    bus0.in_valid = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      bus0.in_data = 16'(i);
      step();
    end
    bus0.in_valid = 1'b0;
    check("t6_pre_rst_data", bus0.out_data, 36);
    rst = 1'b1;
    step();
    check("t6_rst_out_valid", bus0.out_valid, 0);
    check("t6_rst_out_data", bus0.out_data, 0);
    check("t6_rst_in_ready", bus0.in_ready, 0);
    rst = 1'b0;
    #1;
    check("t6_post_rst_in_ready", bus0.in_ready, 1);
    bus0.in_valid = 1'b1;
    bus0.in_data  = 16'd3;
    for (int i = 0; i < 8; i++) step();
    bus0.in_valid = 1'b0;
    check("t6_out_valid", bus0.out_valid, 1);
    check("t6_out_data", bus0.out_data, 24);

    // ACC_W=17, COUNT=4, four 0xFFFF samples.
`ifdef PRODUCT_ACCUMULATOR_SATURATE_EN
    exp_ovf_sum = 17'h1FFFF;
`else
    exp_ovf_sum = 17'h1FFFC;
`endif
    bus1.in_valid = 1'b1;
    bus1.in_data  = 16'hFFFF;
    for (int i = 0; i < 4; i++) step();
    bus1.in_valid = 1'b0;
    check("t3_out_valid", bus1.out_valid, 1);
    check("t3_out_data", bus1.out_data, exp_ovf_sum);
    check("t3_out_overflow", bus1.out_overflow, 1);
    bus1.out_ready = 1'b1;
    step();
    bus1.out_ready = 1'b0;
    check("t3_hs_out_valid", bus1.out_valid, 0);

    // COUNT=1 with out_ready high: 5 then 7, one bubble between accepts.
    bus2.out_ready = 1'b1;
    bus2.in_valid  = 1'b1;
    bus2.in_data   = 16'd5;
    step();
    check("t5_first_valid", bus2.out_valid, 1);
    check("t5_first_data", bus2.out_data, 5);
    check("t5_bubble_in_ready", bus2.in_ready, 0);
    bus2.in_data = 16'd7;
    step();
    check("t5_hs_out_valid", bus2.out_valid, 0);
    check("t5_hs_in_ready", bus2.in_ready, 1);
    step();
    bus2.in_valid = 1'b0;
    check("t5_second_valid", bus2.out_valid, 1);
    check("t5_second_data", bus2.out_data, 7);
    step();
    check("t5_final_hs", bus2.out_valid, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
